// File: rtl/ram_port_arbiter.sv
// Arbitrates the byte-wide main RAM port between misc, fdd and cpu requesters,
// issuing one strobe per granted ce slot and returning ack/data after the access.
module ram_port_arbiter #(
    parameter int AW         = 25,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce,

    input  logic          misc_req,
    input  logic          misc_we,
    input  logic [AW-1:0] misc_addr,
    input  logic [7:0]    misc_din,
    output logic          misc_ack,
    output logic [7:0]    misc_dout,

    input  logic          fdd_req,
    input  logic          fdd_we,
    input  logic [AW-1:0] fdd_addr,
    input  logic [7:0]    fdd_din,
    output logic          fdd_ack,
    output logic [7:0]    fdd_dout,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    cpu_dout,

    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    output logic          busy
);

    localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [2:0]    RD_CNT     = 3'(RD_LAT);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;
    typedef enum logic [1:0] {G_MISC = 2'd0, G_FDD = 2'd1, G_CPU = 2'd2} grant_t;

    state_t          state_q, state_d;
    grant_t          gnt_q, gnt_d, sel;
    logic            we_q, we_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_din_q, mem_din_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_rd_q, mem_rd_d;
    logic [7:0]      misc_dout_q, misc_dout_d;
    logic [7:0]      fdd_dout_q, fdd_dout_d;
    logic [7:0]      cpu_dout_q, cpu_dout_d;

    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_din;
    logic            grant;
    logic            done;
    logic            rd_done;

    // A starved cpu overrides the fixed misc > fdd > cpu order.
    always_comb begin
        sel      = G_MISC;
        sel_we   = misc_we;
        sel_addr = misc_addr;
        sel_din  = misc_din;
        if (cpu_req && (starve_q == STARVE_TOP)) begin
            sel      = G_CPU;
            sel_we   = cpu_we;
            sel_addr = cpu_addr;
            sel_din  = cpu_din;
        end else if (misc_req) begin
            sel      = G_MISC;
        end else if (fdd_req) begin
            sel      = G_FDD;
            sel_we   = fdd_we;
            sel_addr = fdd_addr;
            sel_din  = fdd_din;
        end else begin
            sel      = G_CPU;
            sel_we   = cpu_we;
            sel_addr = cpu_addr;
            sel_din  = cpu_din;
        end
    end

    assign grant = (state_q == S_IDLE) && ce && (misc_req || fdd_req || cpu_req);
    assign done  = (state_q == S_ACCESS) && (cnt_q == 3'd0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= G_MISC;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            misc_dout_q <= 8'd0;
            fdd_dout_q  <= 8'd0;
            cpu_dout_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_rd_q    <= mem_rd_d;
            misc_dout_q <= misc_dout_d;
            fdd_dout_q  <= fdd_dout_d;
            cpu_dout_q  <= cpu_dout_d;
        end
    end

    // Writes finish one cycle after the strobe; reads wait out RD_LAT.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        mem_rd_d    = 1'b0;
        misc_dout_d = misc_dout_q;
        fdd_dout_d  = fdd_dout_q;
        cpu_dout_d  = cpu_dout_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d    = S_ACCESS;
                    gnt_d      = sel;
                    we_d       = sel_we;
                    mem_addr_d = sel_addr;
                    mem_din_d  = sel_din;
                    mem_we_d   = sel_we;
                    mem_rd_d   = ~sel_we;
                    cnt_d      = sel_we ? 3'd1 : RD_CNT;
                end
            end
            S_ACCESS: begin
                if (done) begin
                    state_d = S_IDLE;
                    if (!we_q) begin
                        case (gnt_q)
                            G_MISC:  misc_dout_d = mem_dout;
                            G_FDD:   fdd_dout_d  = mem_dout;
                            default: cpu_dout_d  = mem_dout;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!cpu_req) begin
            starve_d = '0;
        end else if (grant) begin
            if (sel == G_CPU) begin
                starve_d = '0;
            end else if (starve_q != STARVE_TOP) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Read data is forwarded straight from the RAM during the ack cycle.
    always_comb begin
        rd_done   = done && !we_q;
        busy      = (state_q != S_IDLE);
        misc_ack  = done && (gnt_q == G_MISC);
        fdd_ack   = done && (gnt_q == G_FDD);
        cpu_ack   = done && (gnt_q == G_CPU);
        misc_dout = (rd_done && (gnt_q == G_MISC)) ? mem_dout : misc_dout_q;
        fdd_dout  = (rd_done && (gnt_q == G_FDD))  ? mem_dout : fdd_dout_q;
        cpu_dout  = (rd_done && (gnt_q == G_CPU))  ? mem_dout : cpu_dout_q;
        mem_addr  = mem_addr_q;
        mem_din   = mem_din_q;
        mem_we    = mem_we_q;
        mem_rd    = mem_rd_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: transaction-level reference model with
// timestamped accesses, a behavioural RAM, and random requesters.
module tb_ram_port_arbiter;

    localparam int AW         = 25;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam int NCYC       = 3600;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic          reset;
    logic          ce;
    logic [7:0]    mem_dout;
    logic          req_v [3];
    logic          we_v  [3];
    logic [AW-1:0] addr_v[3];
    logic [7:0]    din_v [3];
    logic          misc_ack, fdd_ack, cpu_ack;
    logic [7:0]    misc_dout, fdd_dout, cpu_dout;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we, mem_rd, busy;

    ram_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .misc_req(req_v[0]), .misc_we(we_v[0]), .misc_addr(addr_v[0]), .misc_din(din_v[0]),
        .misc_ack(misc_ack), .misc_dout(misc_dout),
        .fdd_req(req_v[1]), .fdd_we(we_v[1]), .fdd_addr(addr_v[1]), .fdd_din(din_v[1]),
        .fdd_ack(fdd_ack), .fdd_dout(fdd_dout),
        .cpu_req(req_v[2]), .cpu_we(we_v[2]), .cpu_addr(addr_v[2]), .cpu_din(din_v[2]),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Behavioural RAM seen by the DUT, and the reference model's own copy.
    logic [7:0] ram[logic [AW-1:0]];
    logic [7:0] ref_mem[logic [AW-1:0]];

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;
    rd_t rdq[$];

    function automatic logic [7:0] fill(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : fill(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] base;
        case ($urandom_range(0, 2))
            0:       base = '0;
            1:       base = 25'h0080000;
            default: base = 25'h1FFFFF0;
        endcase
        return base + AW'($urandom_range(0, 7));
    endfunction

    // Reference model: the one access in flight, described by timestamps.
    bit            act_valid;
    int            act_port;
    bit            act_we;
    logic [AW-1:0] act_addr;
    logic [7:0]    act_din;
    logic [7:0]    act_rdata;
    int            act_t;
    int            act_ack;
    int            starve;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_din;
    logic [7:0]    exp_dout[3];
    bit            pend[3];
    bit            chk_en = 1'b0;

    function automatic int phase(input int c);
        if (c < 1500) return 0;
        if (c < 2300) return 1;
        return 2;
    endfunction

    function automatic int req_prob(input int ph, input int p);
        if (ph == 0) return 30;
        if (ph == 1) return (p == 1) ? 0 : 100;
        return 50;
    endfunction

    task automatic model_reset();
        act_valid = 1'b0;
        starve    = 0;
        exp_addr  = '0;
        exp_din   = 8'd0;
        for (int p = 0; p < 3; p++) begin
            exp_dout[p] = 8'd0;
            pend[p]     = 1'b0;
        end
    endtask

    task automatic drive();
        int ph;
        ph = phase(cyc);
        if (cyc <= 3)
            reset = 1'b1;
        else if (ph != 1 && !(act_valid && cyc == act_ack) && $urandom_range(0, 79) == 0)
            reset = 1'b1;
        else
            reset = 1'b0;
        case (ph)
            0:       ce = 1'($urandom_range(0, 1));
            1:       ce = 1'b1;
            default: ce = (cyc % 3 == 0);
        endcase
        for (int p = 0; p < 3; p++) begin
            if (pend[p]) begin
                if (act_valid && act_port == p && ph != 1 && $urandom_range(0, 5) == 0)
                    req_v[p] = 1'b0;
            end else if ($urandom_range(0, 99) < req_prob(ph, p)) begin
                pend[p]   = 1'b1;
                req_v[p]  = 1'b1;
                we_v[p]   = 1'($urandom_range(0, 1));
                addr_v[p] = rand_addr();
                din_v[p]  = 8'($urandom);
            end else begin
                req_v[p] = 1'b0;
            end
        end
        while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            mem_dout = rdq[0].data;
            void'(rdq.pop_front());
        end else begin
            mem_dout = 8'($urandom);
        end
    endtask

    task automatic observe();
        bit ack_now, strobe_now, was_idle;
        int win;
        ack_now    = act_valid && (cyc == act_ack);
        strobe_now = act_valid && (cyc == act_t + 1);
        if (ack_now && !act_we) exp_dout[act_port] = act_rdata;
        if (chk_en) begin
            chk("busy", busy, act_valid && (cyc >= act_t + 1));
            chk("mem_we", mem_we, strobe_now && act_we);
            chk("mem_rd", mem_rd, strobe_now && !act_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_din", mem_din, exp_din);
            chk("misc_ack", misc_ack, ack_now && act_port == 0);
            chk("fdd_ack", fdd_ack, ack_now && act_port == 1);
            chk("cpu_ack", cpu_ack, ack_now && act_port == 2);
            chk("misc_dout", misc_dout, exp_dout[0]);
            chk("fdd_dout", fdd_dout, exp_dout[1]);
            chk("cpu_dout", cpu_dout, exp_dout[2]);
        end
        if (mem_we === 1'b1) ram[mem_addr] = mem_din;
        if (mem_rd === 1'b1) rdq.push_back('{due: cyc + RD_LAT, data: ram_rd(mem_addr)});
        if (ack_now) pend[act_port] = 1'b0;
        was_idle = !act_valid;
        if (ack_now) act_valid = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            if (was_idle && ce && (req_v[0] || req_v[1] || req_v[2])) begin
                if (req_v[2] && starve == STARVE_MAX) win = 2;
                else if (req_v[0])                    win = 0;
                else if (req_v[1])                    win = 1;
                else                                  win = 2;
                act_valid = 1'b1;
                act_port  = win;
                act_we    = we_v[win];
                act_addr  = addr_v[win];
                act_din   = din_v[win];
                act_t     = cyc;
                act_ack   = cyc + 1 + (act_we ? 1 : RD_LAT);
                exp_addr  = act_addr;
                exp_din   = act_din;
                if (act_we) ref_mem[act_addr] = act_din;
                else        act_rdata = ref_rd(act_addr);
                if (win == 2)                            starve = 0;
                else if (req_v[2] && starve < STARVE_MAX) starve++;
            end
            if (!req_v[2]) starve = 0;
        end
        if (cyc == 1) chk_en = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        ce       = 1'b0;
        mem_dout = 8'd0;
        for (int p = 0; p < 3; p++) begin
            req_v[p]  = 1'b0;
            we_v[p]   = 1'b0;
            addr_v[p] = '0;
            din_v[p]  = 8'd0;
        end
        model_reset();
        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk_sys);
            #1;
            cyc++;
            drive();
            @(negedge clk_sys);
            observe();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
